// File: rtl/pi_deflect_sched_pkg.sv
// Shared definitions for the pi-switch deflection scheduler: direction codes,
// input index constants, pointer width and a small popcount helper.
package pi_deflect_sched_pkg;

    localparam int PTR_W     = 2;
    localparam int NUM_PORTS = 4;

    // Direction codes double as input/output indices {ur,ul,r,l} = {3,2,1,0}
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UPL   = 2'd2;
    localparam logic [1:0] DIR_UPR   = 2'd3;

    localparam logic [1:0] IDX_L  = 2'd0;
    localparam logic [1:0] IDX_R  = 2'd1;
    localparam logic [1:0] IDX_UL = 2'd2;
    localparam logic [1:0] IDX_UR = 2'd3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pi_alloc_comb.sv
// Combinational three-pass output allocator: productive placement, deflection
// of leftover valid inputs, then filling of idle outputs so sel is a bijection.
module pi_alloc_comb
    import pi_deflect_sched_pkg::*;
#(
    parameter bit HAS_UP = 1'b1
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [3:0]       req_v,
    input  logic [7:0]       req_d,
    output logic [7:0]       sel,
    output logic [3:0]       out_v,
    output logic [3:0]       defl,
    output logic [PTR_W-1:0] first_defl,
    output logic             any_defl
);

    // A root node has no parents: up outputs are reserved for the bijection fill only
    localparam int MAX_OUT = HAS_UP ? 3 : 1;

    logic [3:0] v_s;
    logic [3:0] used_s;
    logic [3:0] placed_s;
    logic [1:0] idx_s;
    logic [1:0] want_s;
    logic [1:0] alt_s;
    logic       found_s;

    assign v_s = HAS_UP ? req_v : {2'b00, req_v[1:0]};

    // Passes 1-3 in priority order starting at ptr
    always_comb begin
        used_s     = 4'b0000;
        placed_s   = 4'b0000;
        idx_s      = 2'd0;
        want_s     = 2'd0;
        alt_s      = 2'd0;
        found_s    = 1'b0;
        sel        = {DIR_UPR, DIR_UPL, DIR_RIGHT, DIR_LEFT};
        out_v      = 4'b0000;
        defl       = 4'b0000;
        first_defl = 2'd0;
        any_defl   = 1'b0;

        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_s  = ptr + 2'(k);
            want_s = req_d[{idx_s, 1'b0} +: 2];
            alt_s  = want_s ^ 2'd1;
            if (v_s[idx_s]) begin
                if (want_s == DIR_LEFT || want_s == DIR_RIGHT) begin
                    if (!used_s[want_s]) begin
                        used_s[want_s]           = 1'b1;
                        placed_s[idx_s]          = 1'b1;
                        out_v[want_s]            = 1'b1;
                        sel[{want_s, 1'b0} +: 2] = idx_s;
                    end else begin
                        placed_s[idx_s] = 1'b0;
                    end
                end else if (HAS_UP) begin
                    // Either parent port moves the packet toward the root
                    if (!used_s[want_s]) begin
                        used_s[want_s]           = 1'b1;
                        placed_s[idx_s]          = 1'b1;
                        out_v[want_s]            = 1'b1;
                        sel[{want_s, 1'b0} +: 2] = idx_s;
                    end else if (!used_s[alt_s]) begin
                        used_s[alt_s]            = 1'b1;
                        placed_s[idx_s]          = 1'b1;
                        out_v[alt_s]             = 1'b1;
                        sel[{alt_s, 1'b0} +: 2]  = idx_s;
                    end else begin
                        placed_s[idx_s] = 1'b0;
                    end
                end else begin
                    placed_s[idx_s] = 1'b0;
                end
            end else begin
                placed_s[idx_s] = placed_s[idx_s];
            end
        end

        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_s   = ptr + 2'(k);
            found_s = 1'b0;
            if (v_s[idx_s] && !placed_s[idx_s]) begin
                for (int o = 0; o < NUM_PORTS; o++) begin
                    if (!found_s && (o <= MAX_OUT) && !used_s[o]) begin
                        used_s[o]       = 1'b1;
                        out_v[o]        = 1'b1;
                        sel[2*o +: 2]   = idx_s;
                        found_s         = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
                placed_s[idx_s] = 1'b1;
                defl[idx_s]     = 1'b1;
                if (!any_defl) begin
                    any_defl   = 1'b1;
                    first_defl = idx_s;
                end else begin
                    any_defl = 1'b1;
                end
            end else begin
                found_s = 1'b0;
            end
        end

        for (int o = 0; o < NUM_PORTS; o++) begin
            found_s = 1'b0;
            if (!used_s[o]) begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (!found_s && !placed_s[j]) begin
                        placed_s[j]   = 1'b1;
                        used_s[o]     = 1'b1;
                        sel[2*o +: 2] = 2'(j);
                        found_s       = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                found_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pi_deflect_sched.sv
// Registered output-port allocator for a bufferless pi-switch node.
// Optional deflection statistics counter enabled by defining PI_SCHED_STATS_EN.
module pi_deflect_sched
    import pi_deflect_sched_pkg::*;
#(
    parameter int LEVEL  = 0,
    parameter bit HAS_UP = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       req_v,
    input  logic [7:0]       req_d,
    output logic [1:0]       sel_l,
    output logic [1:0]       sel_r,
    output logic [1:0]       sel_ul,
    output logic [1:0]       sel_ur,
    output logic [3:0]       out_v,
    output logic [3:0]       defl,
    output logic [CNT_W-1:0] defl_cnt
);

    if (LEVEL < 0 || CNT_W < 3) begin : g_bad_params
        $error("pi_deflect_sched: LEVEL must be >= 0 and CNT_W >= 3");
    end

    logic [PTR_W-1:0] ptr_r;
    logic [7:0]       sel_nxt_s;
    logic [3:0]       out_v_nxt_s;
    logic [3:0]       defl_nxt_s;
    logic [PTR_W-1:0] first_defl_s;
    logic             any_defl_s;

    pi_alloc_comb #(
        .HAS_UP(HAS_UP)
    ) u_alloc (
        .ptr       (ptr_r),
        .req_v     (req_v),
        .req_d     (req_d),
        .sel       (sel_nxt_s),
        .out_v     (out_v_nxt_s),
        .defl      (defl_nxt_s),
        .first_defl(first_defl_s),
        .any_defl  (any_defl_s)
    );

    // Output registers and priority pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_l  <= DIR_LEFT;
            sel_r  <= DIR_RIGHT;
            sel_ul <= DIR_UPL;
            sel_ur <= DIR_UPR;
            out_v  <= 4'b0000;
            defl   <= 4'b0000;
            ptr_r  <= 2'd0;
        end else if (en) begin
            sel_l  <= sel_nxt_s[1:0];
            sel_r  <= sel_nxt_s[3:2];
            sel_ul <= sel_nxt_s[5:4];
            sel_ur <= sel_nxt_s[7:6];
            out_v  <= out_v_nxt_s;
            defl   <= defl_nxt_s;
            // Skip past the first loser so the next input in line gets top priority
            if (any_defl_s) begin
                ptr_r <= first_defl_s + 2'd1;
            end else begin
                ptr_r <= ptr_r;
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

`ifdef PI_SCHED_STATS_EN
    logic [CNT_W:0]   cnt_sum_s;
    logic [CNT_W-1:0] defl_cnt_r;

    // Widened sum so a carry out signals saturation
    always_comb begin
        cnt_sum_s = {1'b0, defl_cnt_r} + {{(CNT_W-2){1'b0}}, popcount4(defl_nxt_s)};
    end

    // Saturating deflection counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            defl_cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            defl_cnt_r <= cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
        end else begin
            defl_cnt_r <= defl_cnt_r;
        end
    end

    assign defl_cnt = defl_cnt_r;
`else
    assign defl_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pi_deflect_sched.sv
// Directed self-checking bench for pi_deflect_sched: one node with parent ports
// and one root node (HAS_UP=0), sharing clock, reset and enable.
module tb_pi_deflect_sched;
    import pi_deflect_sched_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [3:0]       req_v_up, req_v_rt;
    logic [7:0]       req_d_up, req_d_rt;
    logic [1:0]       sel_l_up, sel_r_up, sel_ul_up, sel_ur_up;
    logic [1:0]       sel_l_rt, sel_r_rt, sel_ul_rt, sel_ur_rt;
    logic [3:0]       out_v_up, defl_up, out_v_rt, defl_rt;
    logic [CNT_W-1:0] cnt_up, cnt_rt;

    int n_checks = 0;
    int n_pass   = 0;
    int stats_on;

    always #5 clk = ~clk;

    pi_deflect_sched #(.LEVEL(1), .HAS_UP(1'b1), .CNT_W(CNT_W)) dut_up (
        .clk(clk), .reset_n(reset_n), .en(en), .req_v(req_v_up), .req_d(req_d_up),
        .sel_l(sel_l_up), .sel_r(sel_r_up), .sel_ul(sel_ul_up), .sel_ur(sel_ur_up),
        .out_v(out_v_up), .defl(defl_up), .defl_cnt(cnt_up)
    );

    pi_deflect_sched #(.LEVEL(0), .HAS_UP(1'b0), .CNT_W(CNT_W)) dut_rt (
        .clk(clk), .reset_n(reset_n), .en(en), .req_v(req_v_rt), .req_d(req_d_rt),
        .sel_l(sel_l_rt), .sel_r(sel_r_rt), .sel_ul(sel_ul_rt), .sel_ur(sel_ur_rt),
        .out_v(out_v_rt), .defl(defl_rt), .defl_cnt(cnt_rt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_up(input string tag, input logic [7:0] sel_exp,
                            input logic [3:0] ov_exp, input logic [3:0] df_exp);
        check_eq({tag, ".sel"}, {24'd0, sel_ur_up, sel_ul_up, sel_r_up, sel_l_up}, {24'd0, sel_exp});
        check_eq({tag, ".out_v"}, {28'd0, out_v_up}, {28'd0, ov_exp});
        check_eq({tag, ".defl"}, {28'd0, defl_up}, {28'd0, df_exp});
    endtask

    task automatic check_rt(input string tag, input logic [7:0] sel_exp,
                            input logic [3:0] ov_exp, input logic [3:0] df_exp);
        check_eq({tag, ".sel"}, {24'd0, sel_ur_rt, sel_ul_rt, sel_r_rt, sel_l_rt}, {24'd0, sel_exp});
        check_eq({tag, ".out_v"}, {28'd0, out_v_rt}, {28'd0, ov_exp});
        check_eq({tag, ".defl"}, {28'd0, defl_rt}, {28'd0, df_exp});
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        en       = 1'b0;
        req_v_up = 4'b0000;
        req_d_up = 8'h00;
        req_v_rt = 4'b0000;
        req_d_rt = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
        en      = 1'b1;
    endtask

    // Expected sel vectors packed {ur,ul,r,l}
    localparam logic [7:0] SEL_ID = 8'b11_10_01_00;

    initial begin
`ifdef PI_SCHED_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        do_reset();
        tick();
        check_up("reset", SEL_ID, 4'b0000, 4'b0000);
        check_eq("reset.cnt", {16'd0, cnt_up}, 32'd0);

        // l->RIGHT, r->LEFT, ul->UPL, ur->UPR: no contention
        req_v_up = 4'b1111;
        req_d_up = 8'b11_10_00_01;
        tick();
        check_up("no_contention", 8'b11_10_00_01, 4'b1111, 4'b0000);

        // l and r both want LEFT with ptr still 0: l wins, r deflected to R; ptr -> 2
        req_v_up = 4'b0011;
        req_d_up = 8'b00_00_00_00;
        tick();
        check_up("contention", SEL_ID, 4'b0011, 4'b0010);

        req_v_up = 4'b0000;
        tick();
        check_up("idle", SEL_ID, 4'b0000, 4'b0000);

        // ptr=2 held through idle: ul outranks l for L; l->R, r->UL
        req_v_up = 4'b0111;
        req_d_up = 8'b00_00_00_00;
        tick();
        check_up("ptr_after_idle", 8'b11_01_00_10, 4'b0111, 4'b0011);

        // Four cycles of all inputs wanting LEFT from ptr=0
        do_reset();
        req_v_up = 4'b1111;
        req_d_up = 8'b00_00_00_00;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c % 2 == 0) begin
                check_up($sformatf("all_left%0d", c), SEL_ID, 4'b1111, 4'b1110);
            end else begin
                check_up($sformatf("all_left%0d", c), 8'b01_00_11_10, 4'b1111, 4'b1011);
            end
        end

        // ul and ur both want UPL: both productive
        do_reset();
        req_v_up = 4'b1100;
        req_d_up = 8'b10_10_00_00;
        tick();
        check_up("up_flex", SEL_ID, 4'b1100, 4'b0000);

        req_d_up = 8'b11_11_00_00;
        tick();
        check_up("up_flex_upr", 8'b10_11_01_00, 4'b1100, 4'b0000);

        // en=0 holds outputs even with new requests
        en       = 1'b0;
        req_v_up = 4'b0011;
        req_d_up = 8'b00_00_00_00;
        tick();
        check_up("hold_up", 8'b10_11_01_00, 4'b1100, 4'b0000);

        // Asynchronous reset takes effect before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check_up("async_reset", SEL_ID, 4'b0000, 4'b0000);

        // Root node: l wants UPL (no parents), r wants LEFT
        do_reset();
        req_v_rt = 4'b0011;
        req_d_rt = 8'b00_00_00_10;
        tick();
        check_rt("root", 8'b11_10_00_01, 4'b0011, 4'b0001);
        check_eq("root.cnt", {16'd0, cnt_rt}, (stats_on != 0) ? 32'd1 : 32'd0);

        en       = 1'b0;
        req_v_rt = 4'b1111;
        req_d_rt = 8'b10_10_10_10;
        tick();
        check_rt("root_hold", 8'b11_10_00_01, 4'b0011, 4'b0001);
        check_eq("root_hold.cnt", {16'd0, cnt_rt}, (stats_on != 0) ? 32'd1 : 32'd0);

        // ptr=1; all want UPL; ul/ur ignored; r then l deflected onto L/R
        en = 1'b1;
        tick();
        check_rt("root_up_req", 8'b11_10_00_01, 4'b0011, 4'b0011);
        check_eq("root_up_req.cnt", {16'd0, cnt_rt}, (stats_on != 0) ? 32'd3 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
